// File: rtl/delay_pipe_if.sv
// Control/data bundle for delay_pipe: stall enable, flush and the data/valid path.
// The master drives in/in_valid/en/flush; the slave (the pipe) returns out/out_valid/count.
interface delay_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 4
);
  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [CW-1:0]    count;

  modport master (
    output en, flush, in, in_valid,
    input  out, out_valid, count
  );

  modport slave (
    input  en, flush, in, in_valid,
    output out, out_valid, count
  );
endinterface

// File: rtl/delay_pipe.sv
// CYCLES-deep register chain with shared stall enable, per-stage valid flags,
// synchronous flush of the valid flags and a running occupancy count.
module delay_pipe #(
  parameter int               WIDTH       = 8,
  parameter int               CYCLES      = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  delay_pipe_if.slave bus
);
  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  generate
    if (CYCLES == 0) begin : g_wire
      assign bus.out       = bus.in;
      assign bus.out_valid = bus.in_valid & ~bus.flush;
      assign bus.count     = '0;
    end else begin : g_regs
      logic [WIDTH-1:0]  data_q [CYCLES];
      logic [CYCLES-1:0] valid_q;
      logic [CW-1:0]     count_q;
      logic              last_valid;

      assign last_valid = valid_q[CYCLES-1];

      // Flush only clears the valid flags; data registers keep their contents.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < CYCLES; i++) data_q[i] <= RESET_VALUE;
          valid_q <= '0;
          count_q <= '0;
        end else if (bus.flush) begin
          valid_q <= '0;
          count_q <= '0;
        end else if (bus.en) begin
          data_q[0]  <= bus.in;
          valid_q[0] <= bus.in_valid;
          for (int i = 1; i < CYCLES; i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
          // Intermediate wrap is harmless: count + in - out always lands in 0..CYCLES.
          count_q <= count_q + CW'(bus.in_valid) - CW'(last_valid);
        end
      end

      assign bus.out       = data_q[CYCLES-1];
      assign bus.out_valid = last_valid;
      assign bus.count     = count_q;
    end
  endgenerate
endmodule
